// File: rtl/symbol_aligner.sv
// symbol_aligner: comma-based 10-bit symbol alignment for the recovered clock
// domain. Scans every bit offset of a 20-bit window for K28.5 (either
// disparity), locks onto a repeatedly confirmed offset and emits aligned
// symbols with a comma flag and a lock indication.
// Optional feature: define ALIGN_TIMEOUT_EN to drop lock after TIMEOUT_CYCLES
// cycles without a comma at the locked offset.
module symbol_aligner #(
  parameter int DATA_WIDTH     = 10,
  parameter int LOCK_COUNT     = 3,
  parameter int MISALIGN_LIMIT = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  write_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  comma_det,
  output logic                  symbol_lock,
  output logic [3:0]            align_offset,
  output logic                  realign
);

  // Only 10-bit symbols and 4-bit counter ranges make sense here.
  if (DATA_WIDTH != 10 || LOCK_COUNT < 2 || LOCK_COUNT > 15 ||
      MISALIGN_LIMIT < 1 || MISALIGN_LIMIT > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("symbol_aligner: unsupported parameter value");
  end

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);
  localparam logic [3:0] MIS_CNT4  = 4'(MISALIGN_LIMIT);

  logic [9:0]  r_prev;
  logic [1:0]  r_state;
  logic [3:0]  r_offset;
  logic [3:0]  r_cnt;
  logic [9:0]  r_data_out;
  logic        r_comma_det;
  logic        r_realign;

  logic [19:0] w_win;
  logic [9:0]  w_hit;
  logic        w_any_hit;
  logic [3:0]  w_hit_off;
  logic        w_hit_at_cur;
  logic [3:0]  w_sel_off;
  logic [9:0]  w_sel_word;
  logic        w_sel_hit;
  logic [3:0]  w_cnt_inc;
  logic [1:0]  w_state_next;
  logic [3:0]  w_offset_next;
  logic [3:0]  w_cnt_next;
  logic        w_timeout;

  // Older word sits in the low half, so bit 0 is the earliest received bit.
  assign w_win = {data_in, r_prev};

  // Comma detector per offset: abcdeif = 0011111 (RD-) or 1100000 (RD+).
  for (genvar gi = 0; gi < 10; gi++) begin : g_hit
    assign w_hit[gi] = (w_win[gi+6:gi] == 7'b1111100) ||
                       (w_win[gi+6:gi] == 7'b0000011);
  end

  assign w_any_hit = |w_hit;

  // Lowest offset with a comma wins when several hit in one window.
  always_comb begin
    w_hit_off = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (w_hit[i]) w_hit_off = 4'(i);
    end
  end

  // Is there a comma at the currently held offset?
  always_comb begin
    w_hit_at_cur = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (r_offset == 4'(i)) w_hit_at_cur = w_hit[i];
    end
  end

  // While acquiring, follow a new comma immediately; once locked, hold offset.
  assign w_sel_off = ((r_state == ST_SEARCH || r_state == ST_CONFIRM) &&
                      w_any_hit && (w_hit_off != r_offset)) ? w_hit_off : r_offset;

  // Extract the symbol and its comma flag at the selected offset.
  always_comb begin
    w_sel_word = 10'd0;
    w_sel_hit  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (w_sel_off == 4'(i)) begin
        w_sel_word = w_win[i +: 10];
        w_sel_hit  = w_hit[i];
      end
    end
  end

  // Counter never wraps past its maximum.
  assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

`ifdef ALIGN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_inc;

  assign w_to_inc  = r_to_cnt + 1'b1;
  assign w_timeout = (r_state == ST_LOCKED) && !w_hit_at_cur && (w_to_inc == TO_LIMIT);

  // Count cycles without an aligned comma while locked; idle otherwise.
  always_ff @(posedge write_clk) begin
    if (rst || w_state_next != ST_LOCKED || w_hit_at_cur) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_inc;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Acquisition / lock state machine next-state logic.
  always_comb begin
    w_state_next  = r_state;
    w_offset_next = r_offset;
    w_cnt_next    = r_cnt;
    case (r_state)
      ST_SEARCH: begin
        if (w_any_hit) begin
          w_offset_next = w_hit_off;
          w_cnt_next    = 4'd1;
          w_state_next  = ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        if (w_hit_at_cur) begin
          if (w_cnt_inc == LOCK_CNT4) begin
            w_state_next = ST_LOCKED;
            w_cnt_next   = 4'd0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end else if (w_any_hit) begin
          w_offset_next = w_hit_off;
          w_cnt_next    = 4'd1;
        end
      end
      ST_LOCKED: begin
        if (w_hit_at_cur) begin
          w_cnt_next = 4'd0;
        end else if (w_any_hit) begin
          if (w_cnt_inc == MIS_CNT4) begin
            w_state_next = ST_SEARCH;
            w_cnt_next   = 4'd0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
        if (w_timeout) begin
          w_state_next = ST_SEARCH;
          w_cnt_next   = 4'd0;
        end
      end
      default: begin
        w_state_next = ST_SEARCH;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // State, window history and registered outputs; reset overrides everything.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      r_prev      <= 10'd0;
      r_state     <= ST_SEARCH;
      r_offset    <= 4'd0;
      r_cnt       <= 4'd0;
      r_data_out  <= 10'd0;
      r_comma_det <= 1'b0;
      r_realign   <= 1'b0;
    end else begin
      r_prev      <= data_in;
      r_state     <= w_state_next;
      r_offset    <= w_offset_next;
      r_cnt       <= w_cnt_next;
      r_data_out  <= w_sel_word;
      r_comma_det <= w_sel_hit;
      r_realign   <= (w_offset_next != r_offset);
    end
  end

  assign data_out     = r_data_out;
  assign comma_det    = r_comma_det;
  assign symbol_lock  = (r_state == ST_LOCKED);
  assign align_offset = r_offset;
  assign realign      = r_realign;

endmodule

// File: tb/tb_symbol_aligner.sv
// tb_symbol_aligner: table-driven check of symbol_aligner. Each table record
// places one comma into a serial bit stream (optional reset, extra shift bits,
// filler symbols) and lists the outputs expected when that comma is processed.
module tb_symbol_aligner;

  localparam logic [9:0] K_NEG = 10'b0101111100;  // K28.5 RD-, abcdeifghj 0011111010
  localparam logic [9:0] K_POS = 10'b1010000011;  // K28.5 RD+, abcdeifghj 1100000101
  localparam logic [9:0] FILL  = 10'b0101010101;  // D21.5, alternating bits

  logic       write_clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] data_in = 10'd0;
  logic [9:0] data_out;
  logic       comma_det;
  logic       symbol_lock;
  logic [3:0] align_offset;
  logic       realign;

  symbol_aligner dut (
    .write_clk   (write_clk),
    .rst         (rst),
    .data_in     (data_in),
    .data_out    (data_out),
    .comma_det   (comma_det),
    .symbol_lock (symbol_lock),
    .align_offset(align_offset),
    .realign     (realign)
  );

  always #5 write_clk = ~write_clk;

  typedef struct {
    int         pre_reset;   // 0 none, 1 fresh reset + new stream, 2 reset mid-stream
    int         extra_bits;  // bits inserted to shift the stream alignment
    int         fill_syms;   // filler symbols before the comma
    logic [9:0] sym;
    logic       exp_cd;
    logic       chk_do;
    logic       exp_lock;
    logic [3:0] exp_off;
    logic       exp_realign;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [0:NV-1];

  bit q_bits[$];
  int bits_pushed;
  int words_driven;
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(input int pr, input int ex, input int fl, input logic [9:0] s,
                              input logic cd, input logic cdo, input logic lk,
                              input logic [3:0] off, input logic ra);
    vec_t v;
    v.pre_reset = pr; v.extra_bits = ex; v.fill_syms = fl; v.sym = s;
    v.exp_cd = cd; v.chk_do = cdo; v.exp_lock = lk; v.exp_off = off; v.exp_realign = ra;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) q_bits.push_back(s[i]);
    bits_pushed += 10;
  endtask

  task automatic push_pad(input int n);
    for (int i = 0; i < n; i++) q_bits.push_back((i % 2) == 0);
    bits_pushed += n;
  endtask

  task automatic drive_word();
    logic [9:0] w;
    while (q_bits.size() < 10) push_sym(FILL);
    for (int i = 0; i < 10; i++) w[i] = q_bits.pop_front();
    data_in = w;
    @(posedge write_clk);
    #1;
    words_driven++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " data_out"},     32'(data_out),     32'd0);
    check({tag, " comma_det"},    32'(comma_det),    32'd0);
    check({tag, " symbol_lock"},  32'(symbol_lock),  32'd0);
    check({tag, " align_offset"}, 32'(align_offset), 32'd0);
    check({tag, " realign"},      32'(realign),      32'd0);
  endtask

  task automatic fresh_reset();
    rst = 1'b1;
    data_in = 10'd0;
    @(posedge write_clk);
    #1;
    rst = 1'b0;
    q_bits.delete();
    bits_pushed = 0;
    words_driven = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int d;
    logic exp_late_lock;

    // pre, extra, fill, sym, cd, chk_do, lock, off, realign
    // Acquisition at offset 3, comma every 8 symbols.
    vecs[0]  = mk(1, 3, 7, K_NEG, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1);
    vecs[1]  = mk(0, 0, 7, K_NEG, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0);
    vecs[2]  = mk(0, 0, 7, K_NEG, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
    vecs[3]  = mk(0, 0, 7, K_NEG, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
    // Stream re-shifted to offset 6: three foreign commas tolerated, fourth drops lock.
    vecs[4]  = mk(0, 3, 7, K_NEG, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    vecs[5]  = mk(0, 0, 7, K_NEG, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    vecs[6]  = mk(0, 0, 7, K_NEG, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    vecs[7]  = mk(0, 0, 7, K_NEG, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
    vecs[8]  = mk(0, 0, 7, K_NEG, 1'b1, 1'b1, 1'b0, 4'd6, 1'b1);
    vecs[9]  = mk(0, 0, 7, K_NEG, 1'b1, 1'b1, 1'b0, 4'd6, 1'b0);
    vecs[10] = mk(0, 0, 7, K_NEG, 1'b1, 1'b1, 1'b1, 4'd6, 1'b0);
    // Reset while locked: re-lock needs three fresh commas.
    vecs[11] = mk(2, 0, 7, K_NEG, 1'b1, 1'b1, 1'b0, 4'd6, 1'b1);
    vecs[12] = mk(0, 0, 7, K_NEG, 1'b1, 1'b1, 1'b0, 4'd6, 1'b0);
    vecs[13] = mk(0, 0, 7, K_NEG, 1'b1, 1'b1, 1'b1, 4'd6, 1'b0);
    // CONFIRM restart: offsets 2, 2, 5, 5, 5.
    vecs[14] = mk(1, 2, 3, K_NEG, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1);
    vecs[15] = mk(0, 0, 3, K_POS, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0);
    vecs[16] = mk(0, 3, 3, K_NEG, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1);
    vecs[17] = mk(0, 0, 3, K_POS, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0);
    vecs[18] = mk(0, 0, 3, K_NEG, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0);
    // Straddling comma at offset 7, alternating disparity.
    vecs[19] = mk(1, 7, 2, K_NEG, 1'b1, 1'b1, 1'b0, 4'd7, 1'b1);
    vecs[20] = mk(0, 0, 2, K_POS, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0);
    vecs[21] = mk(0, 0, 2, K_NEG, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0);
    vecs[22] = mk(0, 0, 2, K_POS, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0);

    bits_pushed = 0;
    words_driven = 0;
    fresh_reset();
    check_reset_state("initial reset");

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pre_reset == 1) begin
        fresh_reset();
        check_reset_state($sformatf("rec%0d fresh reset", i));
      end else if (vecs[i].pre_reset == 2) begin
        rst = 1'b1;
        drive_word();
        rst = 1'b0;
        check_reset_state($sformatf("rec%0d mid reset", i));
      end
      push_pad(vecs[i].extra_bits);
      for (int f = 0; f < vecs[i].fill_syms; f++) push_sym(FILL);
      p = bits_pushed;
      push_sym(vecs[i].sym);
      d = p / 10 + 1;
      while (words_driven < d + 1) drive_word();

      check($sformatf("rec%0d comma_det", i),    32'(comma_det),    32'(vecs[i].exp_cd));
      if (vecs[i].chk_do)
        check($sformatf("rec%0d data_out", i),   32'(data_out),     32'(vecs[i].sym));
      check($sformatf("rec%0d symbol_lock", i),  32'(symbol_lock),  32'(vecs[i].exp_lock));
      check($sformatf("rec%0d align_offset", i), 32'(align_offset), 32'(vecs[i].exp_off));
      check($sformatf("rec%0d realign", i),      32'(realign),      32'(vecs[i].exp_realign));
      $display("[TB] rec%0d: comma=%h k=%0d data_out=%h comma_det=%0d lock=%0d off=%0d realign=%0d",
               i, vecs[i].sym, p % 10, data_out, comma_det, symbol_lock, align_offset, realign);

      // realign is a single-cycle pulse
      drive_word();
      check($sformatf("rec%0d realign next", i), 32'(realign), 32'd0);
    end

    // Commas stop after lock at offset 7. One word already followed the last comma.
    for (int c = 0; c < 1022; c++) drive_word();
    check("timeout 1023 cycles lock", 32'(symbol_lock), 32'd1);
    $display("[TB] 1023 cycles after last comma: lock=%0d", symbol_lock);
`ifdef ALIGN_TIMEOUT_EN
    exp_late_lock = 1'b0;
`else
    exp_late_lock = 1'b1;
`endif
    drive_word();
    check("timeout 1024 cycles lock", 32'(symbol_lock), 32'(exp_late_lock));
    $display("[TB] 1024 cycles after last comma: lock=%0d", symbol_lock);
    for (int c = 0; c < 100; c++) drive_word();
    check("timeout 1124 cycles lock", 32'(symbol_lock), 32'(exp_late_lock));
    $display("[TB] 1124 cycles after last comma: lock=%0d", symbol_lock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/symbol_aligner.md
# symbol_aligner

- Recovered-clock-domain stage directly upstream of the elastic buffer.
- Accepts unaligned 10-bit parallel words from the deserializer and searches every bit offset for the K28.5 comma.
- Locks onto the comma boundary after repeated confirmation, then delivers symbol-aligned 10-bit words, a comma flag and a lock indication.
- `data_out` feeds the elastic buffer `data_in`; `symbol_lock` qualifies its writes.

## Interface
Parameters:
- `DATA_WIDTH`, 10: symbol width; only 10 is supported.
- `LOCK_COUNT`, 3: consecutive commas at one offset needed to declare lock (2..15).
- `MISALIGN_LIMIT`, 4: consecutive commas at a foreign offset that drop lock (1..15).
- `TIMEOUT_CYCLES`, 1024: comma-absence limit in LOCKED; used only with `ALIGN_TIMEOUT_EN`.

Ports:
- `write_clk`  in  1: recovered symbol clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `data_in`  in  10: raw deserialized word; bit 0 was received first.
- `data_out`  out  10: aligned symbol, bit 0 = 8b/10b bit a.
- `comma_det`  out  1: `data_out` holds a comma (either disparity) at the selected offset.
- `symbol_lock`  out  1: high in LOCKED state.
- `align_offset`  out  4: currently selected bit offset, 0..9.
- `realign`  out  1: one-cycle pulse when `align_offset` changes value.

## Operation
- Window: `win[19:0] = {data_in, prev_q}`, where `prev_q` is the `data_in` value from the previous cycle.
- Candidate at offset k (0..9) is `win[k+9:k]`.
- Comma hit at k when `win[k+6:k]` == 7'b1111100 (RD−, abcdeif = 0011111) or 7'b0000011 (RD+).
- Multiple hits in one window: the lowest k wins (`hit_off`).
- `sel_off` = `hit_off` if state ∈ {SEARCH, CONFIRM} and a hit exists with `hit_off` ≠ `offset_q`; otherwise `sel_off` = `offset_q`.
- `data_out` is registered as `win[sel_off+9:sel_off]`.
- `comma_det` is registered as a hit at `sel_off`.

State machine (`cnt` is 4 bits; `offset_q` is `align_offset`):
- **SEARCH**
  - Hit → `offset_q` ← `hit_off`, `cnt` ← 1, go to CONFIRM.
  - No hit → stay.
- **CONFIRM**
  - Hit at `offset_q` → `cnt`+1; when the incremented value equals `LOCK_COUNT`, go to LOCKED and clear `cnt`.
  - Hit at any other offset only → `offset_q` ← `hit_off`, `cnt` ← 1, stay.
  - No hit → stay; `cnt` is held.
- **LOCKED**
  - Hit at `offset_q` → `cnt` ← 0.
  - Hit elsewhere with none at `offset_q` → `cnt`+1; when it reaches `MISALIGN_LIMIT`, go to SEARCH and clear `cnt`. `offset_q` is retained until the next acquisition.
  - No hit → `cnt` is held.
  - Hits at both `offset_q` and elsewhere count as a hit at `offset_q`.
- `realign` is high in the cycle after any write of `offset_q` that changes its value.
- Counter widths: `cnt` saturates and never wraps. `TIMEOUT_CYCLES` counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Timing
- Reset: `prev_q` = 0, state = SEARCH, `offset_q` = 0, `cnt` = 0. All outputs 0: `data_out`, `comma_det`, `symbol_lock`, `align_offset`, `realign`.
- Reset asserted mid-operation wins over every transition in that cycle. Outputs read as the reset values on the following edge.
- Latency: window built at edge n (`data_in` at n, `prev_q` from n−1) → `data_out`/`comma_det` valid after edge n+1.
- First comma after reset: its aligned symbol appears on `data_out` 1 cycle later with `comma_det` = 1.
- `symbol_lock` rises on the same edge that outputs the `LOCK_COUNT`-th confirming comma.
- `symbol_lock` falls on the edge that processes the `MISALIGN_LIMIT`-th foreign comma.
- A comma straddling words (k ≥ 4) is detected only once both words are present, i.e. in the cycle its second word arrives.

## Configuration
- `ALIGN_TIMEOUT_EN` defined: in LOCKED, a timeout counter increments every cycle without a hit at `offset_q` and clears on such a hit.
  - When it reaches `TIMEOUT_CYCLES`, state → SEARCH and `symbol_lock` drops on that edge.
  - The counter clears on reset and on leaving LOCKED.
- `ALIGN_TIMEOUT_EN` undefined: no counter is built and `TIMEOUT_CYCLES` is ignored. LOCKED is left only via `MISALIGN_LIMIT`.

## Test plan
- Offset acquisition
  - Stimulus: bit stream of D-symbols carrying a K28.5 (RD− 0011111010) every 8 symbols, shifted by 3 bits.
  - Required: `align_offset` = 3.
  - Required: `symbol_lock` = 1 on the third comma.
  - Required: `data_out` = 10'b0101111100 with `comma_det` = 1 each comma.
- Straddling comma at k = 7 with alternating RD−/RD+ commas (0011111010 / 1100000101).
  - Required: lock at offset 7.
  - Required: `comma_det` = 1 for both polarities.
- Misalignment loss
  - Stimulus: after lock at offset 3, stream re-shifted to offset 6.
  - Required: `symbol_lock` stays 1 for 3 foreign commas, drops on the 4th.
  - Required: next comma → `align_offset` = 6, `realign` pulse.
- CONFIRM restart
  - Stimulus: commas at offsets 2, 2, 5, 5, 5.
  - Required: `align_offset` 2 → 5 with `realign`; lock only on the third comma at offset 5.
- Reset mid-LOCKED
  - Stimulus: `rst` = 1 for 1 cycle.
  - Required: next edge all outputs 0, state SEARCH; re-lock needs 3 new commas.
- With `ALIGN_TIMEOUT_EN`
  - Stimulus: lock achieved, then commas stop.
  - Required: `symbol_lock` drops exactly 1024 cycles after the last aligned comma.
  - Required: without the macro, the same stimulus keeps `symbol_lock` = 1 indefinitely.
